sha256_seq: RTL and testbench

- Iterative SHA-256 compression controller: one round per clock instead of 64 unrolled rounds.
- Accepts 512-bit pre-padded message blocks over a valid/ready handshake and keeps a rolling 16-word W window.
- Carries the chaining value H across multi-block messages and presents the 256-bit digest on a valid/ready output.
- Sits between a message source (padder/UART RX path) and the hex-to-UART TX formatter in the top level.

---
 rtl/sha256_pkg.sv | 75 +++++++
 rtl/sha256_round.sv | 21 ++
 rtl/sha256_seq.sv | 117 +++++++++++
 tb/tb_sha256_seq.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, types and round helper functions for the iterative
// compression controller.
package sha256_pkg;

  typedef logic [31:0]       word_t;
  typedef logic [0:7][31:0]  hash_t;    // word 0 (H0 / a) is the leftmost word
  typedef logic [0:15][31:0] window_t;  // rolling message schedule, W[0] is current

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROUND,
    S_FINAL,
    S_DONE
  } state_e;

  localparam hash_t IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam word_t K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t big_sigma0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t big_sigma1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t small_sigma0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t small_sigma1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic word_t ch(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic word_t maj(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  // Word-wise chaining-value update, carries dropped per word.
  function automatic hash_t hash_add(input hash_t x, input hash_t y);
    hash_t r;
    for (int i = 0; i < 8; i++) r[i] = x[i] + y[i];
    return r;
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 round: working variables a..h in, next a..h out.
module sha256_round
  import sha256_pkg::*;
(
  input  hash_t work_i,  // {a, b, c, d, e, f, g, h}
  input  word_t k_i,
  input  word_t w_i,
  output hash_t work_o
);

  word_t a, b, c, d, e, f, g, h;
  word_t t1, t2;

  always_comb begin
    {a, b, c, d, e, f, g, h} = work_i;
    t1     = h + big_sigma1(e) + ch(e, f, g) + k_i + w_i;
    t2     = big_sigma0(a) + maj(a, b, c);
    work_o = {t1 + t2, a, b, c, d + t1, e, f, g};
  end

endmodule

// File: rtl/sha256_seq.sv
// Iterative SHA-256 compression controller, one round per clock.
// Optional midstate load ports are enabled by defining SHA256_MIDSTATE_EN.
module sha256_seq
  import sha256_pkg::*;
#(
  parameter int FINAL_STAGE = 1
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [0:511]  in_block,
  input  logic          in_first,
  input  logic          in_last,
`ifdef SHA256_MIDSTATE_EN
  input  logic          mid_load,
  input  logic [0:255]  mid_state,
`endif
  output logic          out_valid,
  input  logic          out_ready,
  output logic [0:255]  digest,
  output logic          busy
);

  state_e      state_q, state_d;
  hash_t       h_q, h_d;
  hash_t       work_q, work_d, work_next;
  window_t     w_q, w_d;
  logic [5:0]  rnd_q, rnd_d;
  logic        last_q, last_d;
  hash_t       h_base;
  word_t       w_new;

  sha256_round u_round (
    .work_i (work_q),
    .k_i    (K[rnd_q]),
    .w_i    (w_q[0]),
    .work_o (work_next)
  );

  // NOTE: every variable gets its hold value first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    work_d  = work_q;
    w_d     = w_q;
    rnd_d   = rnd_q;
    last_d  = last_q;
    h_base  = h_q;
    w_new   = small_sigma1(w_q[14]) + w_q[9] + small_sigma0(w_q[1]) + w_q[0];

    unique case (state_q)
      S_IDLE: begin
`ifdef SHA256_MIDSTATE_EN
        if (mid_load) h_base = mid_state;
`endif
        h_d = h_base;
        if (in_valid) begin
          // H also restarts from IV so the final add uses the right base.
          h_d     = in_first ? IV : h_base;
          work_d  = in_first ? IV : h_base;
          w_d     = in_block;
          last_d  = in_last;
          rnd_d   = '0;
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        work_d = work_next;
        w_d    = {w_q[1:15], w_new};
        rnd_d  = rnd_q + 6'd1;
        if (rnd_q == 6'd63) begin
          if (FINAL_STAGE != 0) begin
            state_d = S_FINAL;
          end else begin
            h_d     = hash_add(h_q, work_next);
            state_d = last_q ? S_DONE : S_IDLE;
          end
        end
      end
      S_FINAL: begin
        h_d     = hash_add(h_q, work_q);
        state_d = last_q ? S_DONE : S_IDLE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments here so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      h_q     <= IV;
      work_q  <= '0;
      // NOTE: the W window is a register file but is reset so an abort leaves no message residue.
      w_q     <= '0;
      rnd_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      work_q  <= work_d;
      w_q     <= w_d;
      rnd_q   <= rnd_d;
      last_q  <= last_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign digest    = out_valid ? h_q : '0;

endmodule

// File: tb/tb_sha256_seq.sv
// Directed-vector bench for sha256_seq: known digests, latency, backpressure,
// mid-round reset and (with SHA256_MIDSTATE_EN) midstate continuation.
module tb_sha256_seq;

  localparam int FINAL_STAGE = 1;
  localparam int LAT         = 64 + FINAL_STAGE;

  localparam logic [511:0] ABC_BLK   = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, {15{32'h0}}};
  localparam logic [511:0] TWO_B1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
  };
  localparam logic [511:0] TWO_B2 = {{15{32'h0}}, 32'h000001c0};

  localparam logic [255:0] ABC_DIG =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] EMPTY_DIG =
    256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] TWO_DIG =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  logic          CLK = 1'b0;
  logic          reset;
  logic          in_valid, in_ready, in_first, in_last;
  logic [0:511]  in_block;
  logic          out_valid, out_ready, busy;
  logic [0:255]  digest;
`ifdef SHA256_MIDSTATE_EN
  localparam logic [255:0] MID_H =
    256'h85e655d6_417a1795_3363376a_624cde5c_76e09589_cac5f811_cc4b32c1_f20e533a;
  logic          mid_load;
  logic [0:255]  mid_state;
`endif

  int checks   = 0;
  int failures = 0;

  sha256_seq #(.FINAL_STAGE(FINAL_STAGE)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_block  (in_block),
    .in_first  (in_first),
    .in_last   (in_last),
`ifdef SHA256_MIDSTATE_EN
    .mid_load  (mid_load),
    .mid_state (mid_state),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .digest    (digest),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [511:0] blk, input logic first, input logic last);
    int n = 0;
    while (!in_ready && n < 200) begin tick(); n++; end
    if (!in_ready) check("send_ready_timeout", 256'(in_ready), 256'd1);
    in_block = blk;
    in_first = first;
    in_last  = last;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 200) begin tick(); cyc++; end
  endtask

  task automatic take(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 256'(out_valid), 256'd0);
    check({tag, "_ready_back"}, 256'(in_ready), 256'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   cyc;
    logic stable, saw_valid;

    reset     = 1'b0;
    in_valid  = 1'b0;
    in_first  = 1'b0;
    in_last   = 1'b0;
    in_block  = '0;
    out_ready = 1'b0;
`ifdef SHA256_MIDSTATE_EN
    mid_load  = 1'b0;
    mid_state = '0;
`endif
    tick();
    tick();
    check("rst_in_ready",  256'(in_ready),  256'd1);
    check("rst_out_valid", 256'(out_valid), 256'd0);
    check("rst_busy",      256'(busy),      256'd0);
    check("rst_digest",    256'(digest),    256'd0);
    reset = 1'b1;
    tick();

    // Single-block "abc" with latency and backpressure.
    send(ABC_BLK, 1'b1, 1'b1);
    check("abc_busy",     256'(busy),     256'd1);
    check("abc_in_ready", 256'(in_ready), 256'd0);
    wait_valid(cyc);
    check("abc_latency", 256'(cyc), 256'(LAT));
    check("abc_digest",  256'(digest), ABC_DIG);
    in_block = EMPTY_BLK;
    in_first = 1'b1;
    in_last  = 1'b1;
    in_valid = 1'b1;
    stable   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (digest !== ABC_DIG || !out_valid || in_ready) stable = 1'b0;
    end
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
    check("bp_stable", 256'(stable), 256'd1);
    take("abc");

    // Empty message, out_ready already high before out_valid.
    out_ready = 1'b1;
    send(EMPTY_BLK, 1'b1, 1'b1);
    wait_valid(cyc);
    check("empty_latency", 256'(cyc), 256'(LAT));
    check("empty_digest",  256'(digest), EMPTY_DIG);
    tick();
    check("empty_auto_take", 256'(out_valid), 256'd0);
    out_ready = 1'b0;

    // Two-block message: no digest after the first block.
    send(TWO_B1, 1'b1, 1'b0);
    cyc       = 0;
    saw_valid = 1'b0;
    while (!in_ready && cyc < 200) begin
      tick();
      cyc++;
      if (out_valid) saw_valid = 1'b1;
    end
    check("two_no_mid_valid", 256'(saw_valid), 256'd0);
    check("two_b1_cycles",    256'(cyc),       256'(LAT));
    send(TWO_B2, 1'b0, 1'b1);
    wait_valid(cyc);
    check("two_digest", 256'(digest), TWO_DIG);
    take("two");

    // Reset at round 30 of "abc" discards the partial hash.
    send(ABC_BLK, 1'b1, 1'b1);
    repeat (30) tick();
    check("pre_rst_busy", 256'(busy), 256'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_in_ready",  256'(in_ready),  256'd1);
    check("mid_rst_busy",      256'(busy),      256'd0);
    check("mid_rst_out_valid", 256'(out_valid), 256'd0);
    check("mid_rst_digest",    256'(digest),    256'd0);
    tick();
    reset = 1'b1;
    tick();
    // Non-first block right after reset starts from IV.
    send(EMPTY_BLK, 1'b0, 1'b1);
    wait_valid(cyc);
    check("nofirst_digest", 256'(digest), EMPTY_DIG);
    take("nofirst");
    send(ABC_BLK, 1'b1, 1'b1);
    wait_valid(cyc);
    check("abc_again_digest", 256'(digest), ABC_DIG);
    take("abc_again");

`ifdef SHA256_MIDSTATE_EN
    mid_state = MID_H;
    mid_load  = 1'b1;
    tick();
    mid_load  = 1'b0;
    check("mid_load_idle", 256'(in_ready), 256'd1);
    send(TWO_B2, 1'b0, 1'b1);
    wait_valid(cyc);
    check("midstate_digest", 256'(digest), TWO_DIG);
    take("midstate");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
